// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU result/flag stage.
// Holds the default datapath width, the buffered entry layout and the overflow rule.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int OVF_CNT_W = 8;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic                 zero;
        logic                 cout;
        logic                 ovf;
    } flag_entry_t;

    // Two's-complement overflow of the effective (post-inversion) operands:
    // same-signed inputs producing a result of the opposite sign.
    function automatic logic signed_ovf(
        input logic arith,
        input logic a_msb,
        input logic b_msb,
        input logic inv_a,
        input logic inv_b,
        input logic res_msb
    );
        logic ea;
        logic eb;
        ea = a_msb ^ inv_a;
        eb = b_msb ^ inv_b;
        return arith && (ea == eb) && (res_msb != ea);
    endfunction

endpackage

// File: rtl/alu_skid2.sv
// Two-entry FIFO skid buffer with valid/ready on both sides.
// in_ready depends only on the registered occupancy, never on out_ready.
module alu_skid2
    import alu_pkg::*;
#(
    parameter type entry_t = flag_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   in_valid,
    output logic   in_ready,
    input  entry_t in_data,
    output logic   out_valid,
    input  logic   out_ready,
    output entry_t out_data
);

    entry_t     head_q;
    entry_t     head_d;
    entry_t     tail_q;
    entry_t     tail_d;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       push;
    logic       pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = in_data;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = in_data;
                end else if (push) begin
                    tail_d  = in_data;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
            default: begin
                count_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu_flag_stage.sv
// Registered result/flag stage behind the ripple-carry ALU: derives zero/carry/overflow,
// buffers them in a 2-entry skid FIFO and keeps a saturating overflow event count.
module alu_flag_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = OVF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] result_i,
    input  logic             carry_i,
    input  logic             a_msb_i,
    input  logic             b_msb_i,
    input  logic             invert_a_i,
    input  logic             invert_b_i,
    input  logic             arith_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             ovf_o,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] ovf_cnt_o
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             cout;
        logic             ovf;
    } entry_t;

    entry_t           in_entry;
    entry_t           head;
    logic             push;
    logic [CNT_W-1:0] ovf_cnt_q;
    logic [CNT_W-1:0] ovf_cnt_d;

    always_comb begin
        in_entry.result = result_i;
        in_entry.zero   = (result_i == '0);
        in_entry.cout   = carry_i;
        in_entry.ovf    = signed_ovf(arith_i, a_msb_i, b_msb_i,
                                     invert_a_i, invert_b_i, result_i[WIDTH-1]);
    end

    assign push = in_valid && in_ready;

    alu_skid2 #(
        .entry_t (entry_t)
    ) u_skid (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign result_o = head.result;
    assign zero_o   = head.zero;
    assign cout_o   = head.cout;
    assign ovf_o    = head.ovf;

    // Clear has priority over a same-cycle overflowing push.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (clr_cnt_i) begin
            ovf_cnt_d = '0;
        end else if (push && in_entry.ovf && (ovf_cnt_q != {CNT_W{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt_o = ovf_cnt_q;

endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed plus randomized bench for alu_flag_stage against an operand-level arithmetic model.
module tb_alu_flag_stage;

    localparam int W  = 32;
    localparam int CW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  result_i = '0;
    logic          carry_i = 1'b0;
    logic          a_msb_i = 1'b0;
    logic          b_msb_i = 1'b0;
    logic          invert_a_i = 1'b0;
    logic          invert_b_i = 1'b0;
    logic          arith_i = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result_o;
    logic          zero_o;
    logic          cout_o;
    logic          ovf_o;
    logic          clr_cnt_i = 1'b0;
    logic [CW-1:0] ovf_cnt_o;

    always #5 clk_i = ~clk_i;

    alu_flag_stage #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .result_i   (result_i),
        .carry_i    (carry_i),
        .a_msb_i    (a_msb_i),
        .b_msb_i    (b_msb_i),
        .invert_a_i (invert_a_i),
        .invert_b_i (invert_b_i),
        .arith_i    (arith_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .cout_o     (cout_o),
        .ovf_o      (ovf_o),
        .clr_cnt_i  (clr_cnt_i),
        .ovf_cnt_o  (ovf_cnt_o)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   exp_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Operation seen as signed integer addition of the effective operands plus carry-in.
    task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ia, input logic ib, input logic ar);
        logic [W-1:0] ae;
        logic [W-1:0] be;
        logic [W:0]   usum;
        longint       s;
        ae   = ia ? ~a : a;
        be   = ib ? ~b : b;
        usum = {1'b0, ae} + {1'b0, be} + 33'(ib);
        s    = longint'($signed(ae)) + longint'($signed(be)) + longint'(ib);
        cur.res  = usum[W-1:0];
        cur.cout = usum[W];
        cur.zero = (usum[W-1:0] == '0);
        cur.ovf  = ar && ((s > 64'sd2147483647) || (s < -64'sd2147483648));
        result_i   = usum[W-1:0];
        carry_i    = usum[W];
        a_msb_i    = a[W-1];
        b_msb_i    = b[W-1];
        invert_a_i = ia;
        invert_b_i = ib;
        arith_i    = ar;
    endtask

    task automatic cycle();
        bit push;
        bit pop;
        check("in_ready", 64'(in_ready), 64'(q.size() < 2));
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("result_o", 64'(result_o), 64'(q[0].res));
            check("zero_o", 64'(zero_o), 64'(q[0].zero));
            check("cout_o", 64'(cout_o), 64'(q[0].cout));
            check("ovf_o", 64'(ovf_o), 64'(q[0].ovf));
        end
        check("ovf_cnt_o", 64'(ovf_cnt_o), 64'(exp_cnt));
        push = in_valid && (q.size() < 2);
        pop  = out_ready && (q.size() != 0);
        @(posedge clk_i);
        #1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(cur);
        if (clr_cnt_i) exp_cnt = 0;
        else if (push && cur.ovf && exp_cnt < 255) exp_cnt++;
        vectors++;
    endtask

    initial begin
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_result", 64'(result_o), 64'd0);
        check("rst_flags", 64'({zero_o, cout_o, ovf_o}), 64'd0);
        check("rst_cnt", 64'(ovf_cnt_o), 64'd0);
        rst_i = 1'b0;

        // -1 + 1: zero result with carry, no overflow
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        cycle();
        in_valid = 1'b0;
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_flags", 64'({zero_o, cout_o, ovf_o}), 64'b110);
        cycle();

        // max positive + 1
        in_valid = 1'b1;
        set_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        cycle();
        in_valid = 1'b0;
        check("t2_ovf", 64'(ovf_o), 64'd1);
        check("t2_result", 64'(result_o), 64'h8000_0000);
        check("t2_cnt", 64'(ovf_cnt_o), 64'd1);
        cycle();

        // min negative - 1, then same operands as a non-arithmetic op
        in_valid = 1'b1;
        set_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1);
        cycle();
        check("t3_ovf", 64'(ovf_o), 64'd1);
        check("t3_result", 64'(result_o), 64'h7FFF_FFFF);
        set_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b0);
        cycle();
        in_valid = 1'b0;
        check("t3_noovf", 64'(ovf_o), 64'd0);
        cycle();
        check("t3_cnt", 64'(ovf_cnt_o), 64'd2);

        // backpressure: three back-to-back ops with consumer stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_op(32'd10, 32'd20, 1'b0, 1'b0, 1'b1);
        cycle();
        set_op(32'd100, 32'd7, 1'b0, 1'b1, 1'b1);
        cycle();
        check("bp_full", 64'(in_ready), 64'd0);
        set_op(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b1);
        cycle();
        cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (q.size() < 2 && i == 0) begin
                cycle();
                in_valid = 1'b0;
            end
        end
        check("bp_drain", 64'(out_valid), 64'd0);

        // saturation of the overflow counter
        in_valid = 1'b1;
        set_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 260; i++) cycle();
        check("sat_cnt", 64'(ovf_cnt_o), 64'd255);
        clr_cnt_i = 1'b1;
        cycle();
        clr_cnt_i = 1'b0;
        in_valid  = 1'b0;
        check("clr_cnt", 64'(ovf_cnt_o), 64'd0);
        cycle();
        cycle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            clr_cnt_i = ($urandom_range(49) == 0);
            set_op($urandom, ($urandom_range(7) == 0) ? 32'h0 : $urandom,
                   1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            cycle();
        end
        clr_cnt_i = 1'b0;

        // reset with two entries buffered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
        while (q.size() < 2 && vectors < 5000) cycle();
        check("pre_rst_full", 64'(out_valid && !in_ready), 64'd1);
        in_valid = 1'b0;
        #3;
        rst_i = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_cnt", 64'(ovf_cnt_o), 64'd0);
        check("arst_result", 64'(result_o), 64'd0);
        q.delete();
        exp_cnt = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_op(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_flag_stage.md
# alu_flag_stage

Registered result/flag stage directly downstream of the ripple-carry ALU array (LSB slice plus upper slices). Captures each ALU result with its carry-out and effective operand sign bits, derives zero and signed-overflow flags, and holds them in a 2-entry skid buffer under a valid/ready handshake toward the writeback/branch logic. Also keeps a saturating count of overflowing arithmetic operations for debug.

## Interface
Parameters:
- WIDTH, 32, ALU datapath width in bits.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid  in  1  ALU outputs on this cycle are a valid operation.
- in_ready  out  1  stage can accept an operation this cycle.
- result_i  in  WIDTH  ALU result word.
- carry_i  in  1  carry-out of the MSB slice.
- a_msb_i  in  1  operand A bit WIDTH-1 before inversion.
- b_msb_i  in  1  operand B bit WIDTH-1 before inversion.
- invert_a_i  in  1  invertA control applied to all slices.
- invert_b_i  in  1  invertB control applied to all slices.
- arith_i  in  1  operation is add/sub/slt; overflow meaningful only when 1.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head entry this cycle.
- result_o  out  WIDTH  head result.
- zero_o  out  1  head result == 0.
- cout_o  out  1  head carry-out.
- ovf_o  out  1  head signed overflow.
- clr_cnt_i  in  1  synchronous clear of overflow counter.
- ovf_cnt_o  out  CNT_W  saturating count of accepted overflowing operations.

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- Flags computed combinationally at push, stored with entry: ea = a_msb_i ^ invert_a_i, eb = b_msb_i ^ invert_b_i; ovf = arith_i && (ea == eb) && (result_i[WIDTH-1] != ea); zero = (result_i == 0); cout = carry_i.
- Buffer: 2 entries, FIFO order, occupancy count 0..2. in_ready = (count < 2), derived from registered count only (no combinational path from out_ready).
- out_valid = (count != 0); result_o/zero_o/cout_o/ovf_o show head entry; hold stable while out_valid && !out_ready.
- Count transitions: push only +1, pop only -1, push and pop together unchanged (legal at count 1; at count 0 push only; at count 2 pop only since in_ready=0).
- Overflow counter: on push with ovf=1, increment, saturate at 2^CNT_W-1. clr_cnt_i forces 0 next cycle; clear wins over simultaneous increment.
- in_valid with in_ready=0: operation not captured, upstream must hold it.

## Timing
- Reset: count=0, out_valid=0, in_ready=1, result_o=0, zero_o=0, cout_o=0, ovf_o=0, ovf_cnt_o=0; buffer contents cleared.
- Latency: push in cycle N -> out_valid=1 with that entry in cycle N+1 when buffer was empty.
- Throughput: 1 operation/cycle sustained when out_ready held high.
- Reset asserted mid-operation discards all entries immediately; no partial pop.
- ovf_cnt_o updates one cycle after the push that caused it.

## Structure
- Shared package alu_pkg: WIDTH default, flag_entry_t struct (result, zero, cout, ovf), overflow-function helper.
- One sub-module: alu_skid2, generic 2-entry FIFO of flag_entry_t with valid/ready; flag logic and counter stay in the top.

## Test plan
- Reset then push result_i=0, carry_i=1, arith_i=1, out_ready=1 -> next cycle out_valid=1, zero_o=1, cout_o=1, ovf_o=0.
- Add 0x7FFFFFFF+1: a_msb=0, b_msb=0, inverts 0, result_i=0x80000000 -> ovf_o=1, ovf_cnt_o=1.
- Sub 0x80000000-1: a_msb=1, b_msb=0, invert_b=1, result_i=0x7FFFFFFF -> ovf_o=1; same operands with arith_i=0 -> ovf_o=0, counter unchanged.
- out_ready=0, push 3 ops back-to-back -> in_ready drops after 2nd, 3rd held; release out_ready -> entries out in order, 3rd accepted, no loss/duplication.
- 260 consecutive overflowing pushes -> ovf_cnt_o=255; clr_cnt_i with simultaneous overflowing push -> ovf_cnt_o=0.
- Assert rst_i with 2 entries buffered -> out_valid=0, in_ready=1, ovf_cnt_o=0 immediately.
